// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pipelined bus requests, prefetch queue, redirect flush
// Optional macro FETCH_BYPASS_EN: forward a response to the core in the same cycle when the queue is empty
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t        state;
  state_t        state_n;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] q_count;
  logic [CW-1:0] outs;
  logic [CW-1:0] disc;
  logic [CW-1:0] q_count_n;
  logic [CW-1:0] outs_n;
  logic [CW-1:0] disc_n;
  logic [CW+1:0] credit_sum;
  logic          credit_ok;
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;
  logic [PW-1:0] pc_wr;
  logic [PW-1:0] pc_rd;
  logic [31:0]   q_data  [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   pc_fifo [DEPTH];
  logic [31:0]   redirect_target;
  logic          acc;
  logic          resp_live;
  logic          drop;
  logic          take;
  logic          q_push;
  logic          q_pop;

  assign redirect_target = redirect_pc_i & ~32'h0000_0003;
  assign imem_addr_o     = fetch_pc;
  assign acc             = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding and nothing to discard is a protocol error and is ignored.
  assign resp_live       = imem_rvalid_i && ((disc != '0) || (outs != '0));
  assign drop            = imem_rvalid_i && (disc != '0);
  assign take            = imem_rvalid_i && (disc == '0) && (outs != '0);
  assign q_pop           = (q_count != '0) && inst_ready_i;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit   = take && (q_count == '0) && !redirect_i;
  assign q_push       = take && !(bypass_hit && inst_ready_i);
  assign inst_valid_o = (q_count != '0) || bypass_hit;
  assign inst_o       = bypass_hit ? imem_rdata_i : q_data[q_rd];
  assign inst_pc_o    = bypass_hit ? pc_fifo[pc_rd] : q_pc[q_rd];
`else
  assign q_push       = take;
  assign inst_valid_o = (q_count != '0);
  assign inst_o       = q_data[q_rd];
  assign inst_pc_o    = q_pc[q_rd];
`endif

  // Next counter values and credit; a redirect folds everything in flight into the discard count.
  always_comb begin
    q_count_n = q_count;
    outs_n    = outs;
    disc_n    = disc;
    if (redirect_i) begin
      q_count_n = '0;
      outs_n    = '0;
      disc_n    = outs + disc + CW'(acc) - CW'(resp_live);
    end else begin
      q_count_n = q_count + CW'(q_push) - CW'(q_pop);
      outs_n    = outs + CW'(acc) - CW'(take);
      disc_n    = disc - CW'(drop);
    end
    credit_sum = (CW+2)'(q_count_n) + (CW+2)'(outs_n) + (CW+2)'(disc_n);
    credit_ok  = credit_sum < (CW+2)'(DEPTH);
    if (redirect_i || (state == IDLE)) begin
      state_n = FETCH;
    end else if (credit_ok) begin
      state_n = FETCH;
    end else begin
      state_n = FULL;
    end
  end

  // Fetch FSM, request/credit counters and queue pointers; request is registered from next-state credit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      imem_req_o <= 1'b0;
      fetch_pc   <= RESET_PC;
      q_count    <= '0;
      outs       <= '0;
      disc       <= '0;
      q_wr       <= '0;
      q_rd       <= '0;
      pc_wr      <= '0;
      pc_rd      <= '0;
    end else begin
      state      <= state_n;
      imem_req_o <= (state_n == FETCH) && credit_ok;
      q_count    <= q_count_n;
      outs       <= outs_n;
      disc       <= disc_n;
      if (redirect_i) begin
        fetch_pc <= redirect_target;
        q_wr     <= '0;
        q_rd     <= '0;
        pc_wr    <= '0;
        pc_rd    <= '0;
      end else begin
        if (acc) begin
          fetch_pc <= fetch_pc + 32'd4;
          pc_wr    <= pc_wr + PW'(1);
        end
        if (take) begin
          pc_rd <= pc_rd + PW'(1);
        end
        if (q_push) begin
          q_wr <= q_wr + PW'(1);
        end
        if (q_pop) begin
          q_rd <= q_rd + PW'(1);
        end
      end
    end
  end

  // Prefetch queue storage; cleared on reset so the head reads zero before the first fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (q_push && !redirect_i) begin
      q_data[q_wr] <= imem_rdata_i;
      q_pc[q_wr]   <= pc_fifo[pc_rd];
    end
  end

  // PC of each granted request, consumed in order as responses return.
  always_ff @(posedge clock) begin
    if (acc && !redirect_i) begin
      pc_fifo[pc_wr] <= fetch_pc;
    end
  end

endmodule
